// File: rtl/tx_stream.sv
// tx_stream: transmit endpoint of the valid/ready word interface.
// Producer words are queued in a small circular FIFO and launched one at a
// time into a separate output register, where each word is held on data_o
// until the receiver accepts it. Total buffering is DEPTH+1 words.
module tx_stream #(
    parameter int N     = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [N-1:0]             wr_data_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    input  logic                     hold_i,
    output logic                     valid_o,
    output logic [N-1:0]             data_o,
    input  logic                     ready_i,
    output logic [15:0]              sent_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]    state;
    logic [0:0]    state_next;
    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          wr_accept;
    logic          xfer;
    logic          pop;

    // Flags are derived from the occupancy so they move on the same edge as it.
    assign count_o = count;
    assign full_o  = (count == CW'(DEPTH));
    assign empty_o = (count == '0);
    assign valid_o = (state == SEND);

    // A write is only taken when there is room before the edge, even if a pop
    // frees a slot on that same edge.
    assign wr_accept = wr_en_i && !full_o;

    // A transfer completes whenever a presented word meets ready.
    assign xfer = (state == SEND) && ready_i;

    // The output register may load a new word when it is free or being freed,
    // the FIFO has a word, and the producer side is not holding off launches.
    assign pop = !empty_o && !hold_i && ((state == IDLE) || xfer);

    // Next state: launching keeps/enters SEND, a transfer with no successor returns to IDLE.
    always_comb begin
        state_next = state;
        if (pop) begin
            state_next = SEND;
        end else if (xfer) begin
            state_next = IDLE;
        end
    end

    // State register; reset drops valid_o immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FIFO storage carries no reset; only the pointers define its contents.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= wr_data_i;
        end
    end

    // Pointers and occupancy, with simultaneous write and pop cancelling out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Output word register; keeps its last value after valid_o falls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_o <= '0;
        end else if (pop) begin
            data_o <= mem[rd_ptr];
        end
    end

    // Sticky overflow flag for writes attempted while full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_o <= 1'b0;
        end else if (wr_en_i && full_o) begin
            overflow_o <= 1'b1;
        end
    end

    // Completed-transfer counter, wrapping naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sent_cnt_o <= '0;
        end else if (xfer) begin
            sent_cnt_o <= sent_cnt_o + 16'd1;
        end
    end

endmodule

// File: tb/tb_tx_stream.sv
// tb_tx_stream: directed vector table, hand-written corner sequences and a
// randomized run checked against a queue-based reference model of tx_stream.
module tb_tx_stream;

    logic        clk;
    logic        rst;
    logic        wr_en_i;
    logic [3:0]  wr_data_i;
    logic        full_o;
    logic        empty_o;
    logic [2:0]  count_o;
    logic        overflow_o;
    logic        hold_i;
    logic        valid_o;
    logic [3:0]  data_o;
    logic        ready_i;
    logic [15:0] sent_cnt_o;

    int n_vec  = 0;
    int n_fail = 0;

    tx_stream #(.N(4), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (wr_en_i),
        .wr_data_i  (wr_data_i),
        .full_o     (full_o),
        .empty_o    (empty_o),
        .count_o    (count_o),
        .overflow_o (overflow_o),
        .hold_i     (hold_i),
        .valid_o    (valid_o),
        .data_o     (data_o),
        .ready_i    (ready_i),
        .sent_cnt_o (sent_cnt_o)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        do_reset;
        logic        wr_en;
        logic [3:0]  wr_data;
        logic        hold;
        logic        ready;
        logic        exp_valid;
        logic [3:0]  exp_data;
        logic [2:0]  exp_count;
        logic        exp_full;
        logic        exp_empty;
        logic        exp_ovf;
        logic [15:0] exp_sent;
    } vec_t;

    vec_t vq[$];

    // Reference model state: queued words, offered word and counters.
    logic [3:0]  mq[$];
    logic        m_offer;
    logic [3:0]  m_data;
    logic        m_ovf;
    logic [15:0] m_sent;

    task automatic addVec(input logic rs, input logic we, input logic [3:0] wd,
                          input logic h, input logic rd, input logic ev,
                          input logic [3:0] ed, input logic [2:0] ec,
                          input logic ef, input logic ee, input logic eo,
                          input logic [15:0] es);
        vec_t v;
        v.do_reset = rs; v.wr_en = we; v.wr_data = wd; v.hold = h; v.ready = rd;
        v.exp_valid = ev; v.exp_data = ed; v.exp_count = ec; v.exp_full = ef;
        v.exp_empty = ee; v.exp_ovf = eo; v.exp_sent = es;
        vq.push_back(v);
    endtask

    task automatic checkField(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string tag, input logic ev, input logic [3:0] ed,
                               input logic [2:0] ec, input logic ef, input logic ee,
                               input logic eo, input logic [15:0] es);
        checkField({tag, ".valid"},    16'(valid_o),    16'(ev));
        checkField({tag, ".data"},     16'(data_o),     16'(ed));
        checkField({tag, ".count"},    16'(count_o),    16'(ec));
        checkField({tag, ".full"},     16'(full_o),     16'(ef));
        checkField({tag, ".empty"},    16'(empty_o),    16'(ee));
        checkField({tag, ".overflow"}, 16'(overflow_o), 16'(eo));
        checkField({tag, ".sent"},     sent_cnt_o,      es);
    endtask

    // Drive inputs away from the edge, then let one rising edge pass.
    task automatic applyStimulus(input logic we, input logic [3:0] wd,
                                 input logic h, input logic rd);
        wr_en_i   = we;
        wr_data_i = wd;
        hold_i    = h;
        ready_i   = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        wr_en_i = 1'b0; wr_data_i = '0; hold_i = 1'b0; ready_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic modelReset();
        mq.delete();
        m_offer = 1'b0;
        m_data  = '0;
        m_ovf   = 1'b0;
        m_sent  = '0;
    endtask

    // One clock edge of the intended behaviour, computed from pre-edge state.
    task automatic modelStep(input logic we, input logic [3:0] wd,
                             input logic h, input logic rd);
        int  sz;
        logic transfer;
        logic launch;
        sz       = mq.size();
        transfer = m_offer && rd;
        launch   = (!m_offer || transfer) && (sz > 0) && !h;
        if (we && sz == 4) m_ovf = 1'b1;
        if (transfer) m_sent = m_sent + 16'd1;
        if (launch) m_data = mq.pop_front();
        if (we && sz < 4) mq.push_back(wd);
        if (launch) m_offer = 1'b1;
        else if (transfer) m_offer = 1'b0;
    endtask

    initial begin
        logic        r_we, r_h, r_rd;
        logic [3:0]  r_wd;
        logic [15:0] kw;

        rst = 1'b1;
        wr_en_i = 1'b0; wr_data_i = '0; hold_i = 1'b0; ready_i = 1'b0;
        #2;
        checkOutput("reset_async", 1'b0, 4'h0, 3'd0, 1'b0, 1'b1, 1'b0, 16'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("reset", 1'b0, 4'h0, 3'd0, 1'b0, 1'b1, 1'b0, 16'd0);

        // Single word, backpressure, fill/overflow, hold-off, write+pop at full.
        addVec(0,1,4'hA,0,0, 0,4'h0,3'd0+3'd1,0,0,0,16'd0);
        addVec(0,0,4'h0,0,0, 1,4'hA,3'd0,0,1,0,16'd0);
        addVec(0,0,4'h0,0,1, 0,4'hA,3'd0,0,1,0,16'd1);
        addVec(0,1,4'h3,0,0, 0,4'hA,3'd1,0,0,0,16'd1);
        addVec(0,0,4'h0,0,0, 1,4'h3,3'd0,0,1,0,16'd1);
        for (int i = 0; i < 5; i++) addVec(0,0,4'h0,0,0, 1,4'h3,3'd0,0,1,0,16'd1);
        addVec(0,0,4'h0,0,1, 0,4'h3,3'd0,0,1,0,16'd2);
        addVec(0,1,4'h1,0,0, 0,4'h3,3'd1,0,0,0,16'd2);
        addVec(0,1,4'h2,0,0, 1,4'h1,3'd1,0,0,0,16'd2);
        addVec(0,1,4'h3,0,0, 1,4'h1,3'd2,0,0,0,16'd2);
        addVec(0,1,4'h4,0,0, 1,4'h1,3'd3,0,0,0,16'd2);
        addVec(0,1,4'h5,0,0, 1,4'h1,3'd4,1,0,0,16'd2);
        addVec(0,1,4'h6,0,0, 1,4'h1,3'd4,1,0,1,16'd2);
        addVec(0,0,4'h0,0,1, 1,4'h2,3'd3,0,0,1,16'd3);
        addVec(0,0,4'h0,0,1, 1,4'h3,3'd2,0,0,1,16'd4);
        addVec(0,0,4'h0,0,1, 1,4'h4,3'd1,0,0,1,16'd5);
        addVec(0,0,4'h0,0,1, 1,4'h5,3'd0,0,1,1,16'd6);
        addVec(0,0,4'h0,0,1, 0,4'h5,3'd0,0,1,1,16'd7);
        addVec(0,1,4'h7,1,0, 0,4'h5,3'd1,0,0,1,16'd7);
        addVec(0,1,4'h8,1,0, 0,4'h5,3'd2,0,0,1,16'd7);
        addVec(0,0,4'h0,1,0, 0,4'h5,3'd2,0,0,1,16'd7);
        addVec(0,0,4'h0,0,0, 1,4'h7,3'd1,0,0,1,16'd7);
        addVec(0,0,4'h0,1,0, 1,4'h7,3'd1,0,0,1,16'd7);
        addVec(0,0,4'h0,1,1, 0,4'h7,3'd1,0,0,1,16'd8);
        addVec(1,1,4'h9,0,0, 0,4'h0,3'd1,0,0,0,16'd0);
        addVec(0,1,4'hA,0,0, 1,4'h9,3'd1,0,0,0,16'd0);
        addVec(0,1,4'hB,0,0, 1,4'h9,3'd2,0,0,0,16'd0);
        addVec(0,1,4'hC,0,0, 1,4'h9,3'd3,0,0,0,16'd0);
        addVec(0,1,4'hD,0,0, 1,4'h9,3'd4,1,0,0,16'd0);
        addVec(0,1,4'hE,0,1, 1,4'hA,3'd3,0,0,1,16'd1);
        addVec(0,0,4'h0,0,1, 1,4'hB,3'd2,0,0,1,16'd2);
        addVec(0,1,4'hF,0,1, 1,4'hC,3'd2,0,0,1,16'd3);
        addVec(0,0,4'h0,0,1, 1,4'hD,3'd1,0,0,1,16'd4);
        addVec(0,0,4'h0,0,1, 1,4'hF,3'd0,0,1,1,16'd5);
        addVec(0,0,4'h0,0,1, 0,4'hF,3'd0,0,1,1,16'd6);

        foreach (vq[i]) begin
            if (vq[i].do_reset) doReset();
            applyStimulus(vq[i].wr_en, vq[i].wr_data, vq[i].hold, vq[i].ready);
            checkOutput($sformatf("vec%0d", i), vq[i].exp_valid, vq[i].exp_data,
                        vq[i].exp_count, vq[i].exp_full, vq[i].exp_empty,
                        vq[i].exp_ovf, vq[i].exp_sent);
        end

        // Reset asserted while a word is offered must clear outputs without a clock edge.
        doReset();
        applyStimulus(1'b1, 4'h5, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'h6, 1'b0, 1'b0);
        checkOutput("pre_midrst", 1'b1, 4'h5, 3'd1, 1'b0, 1'b0, 1'b0, 16'd0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst", 1'b0, 4'h0, 3'd0, 1'b0, 1'b1, 1'b0, 16'd0);
        wr_en_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Sent counter wrap: streaming at one word per cycle.
        doReset();
        for (int k = 0; k < 65537; k++) begin
            kw = 16'(k);
            applyStimulus(1'b1, kw[3:0], 1'b0, 1'b1);
        end
        checkOutput("wrap_ffff", 1'b1, 4'hF, 3'd1, 1'b0, 1'b0, 1'b0, 16'hFFFF);
        applyStimulus(1'b1, 4'h1, 1'b0, 1'b1);
        checkOutput("wrap_zero", 1'b1, 4'h0, 3'd1, 1'b0, 1'b0, 1'b0, 16'h0000);

        // Randomized traffic against the reference model.
        doReset();
        modelReset();
        for (int c = 0; c < 3000; c++) begin
            r_we = ($urandom_range(0, 99) < 60);
            r_wd = 4'($urandom_range(0, 15));
            r_h  = ($urandom_range(0, 99) < 15);
            r_rd = ($urandom_range(0, 99) < 50);
            modelStep(r_we, r_wd, r_h, r_rd);
            applyStimulus(r_we, r_wd, r_h, r_rd);
            checkOutput($sformatf("rand%0d", c), m_offer, m_data, 3'(mq.size()),
                        (mq.size() == 4), (mq.size() == 0), m_ovf, m_sent);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
